// File: rtl/gen_audio_if.sv
// rtl/gen_audio_if.sv - output-port write bus from the CPU datapath into the tone generator
interface gen_audio_if #(parameter int WIDTH = 8);
  logic             we;
  logic             addr;
  logic [WIDTH-1:0] din;

  modport master (output we, addr, din);
  modport slave  (input  we, addr, din);
endinterface

// File: rtl/gen_audio.sv
// rtl/gen_audio.sv - buzzer square-wave tone generator with duration ticks
// Optional feature macro: GEN_AUDIO_PENDING_EN (one-entry queued note).
module gen_audio #(
  parameter int WIDTH    = 8,
  parameter int PRESC    = 256,
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  gen_audio_if.slave  bus,
  output logic        audio,
  output logic        busy,
  output logic        pend,
  output logic        done
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = WIDTH + $clog2(PRESC);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] per_act;
  logic [7:0]       dur_q;
  logic [TW-1:0]    tick_cnt;
  logic [HW-1:0]    half_cnt;
  logic [HW-1:0]    half_term;
  logic [7:0]       dur_in;
  logic [7:0]       load_dur;
  logic             wr_period, wr_start, wr_stop;
  logic             tick_last, half_last, note_end;
  logic             start_note, end_note;

  assign dur_in    = 8'(bus.din);
  assign wr_period = bus.we && !bus.addr;
  assign wr_start  = bus.we && bus.addr && (bus.din != '0);
  assign wr_stop   = bus.we && bus.addr && (bus.din == '0);

  // per_act holds the period latched at the last toggle, so a new period
  // write never shortens the half-period already in progress.
  assign half_term = HW'((HW'(per_act) + HW'(1)) * HW'(PRESC)) - HW'(1);
  assign half_last = (half_cnt == half_term);
  assign tick_last = (tick_cnt == TW'(TICK_DIV - 1));
  assign note_end  = (state == PLAY) && tick_last && (dur_q == 8'd1);

`ifdef GEN_AUDIO_PENDING_EN
  logic [7:0] pend_dur;
`endif

  always_comb begin
    start_note = 1'b0;
    end_note   = 1'b0;
    load_dur   = dur_in;
    if (state == IDLE) begin
      start_note = wr_start;
    end else if (!wr_stop) begin
      if (note_end) begin
        end_note = 1'b1;
`ifdef GEN_AUDIO_PENDING_EN
        if (pend) begin
          start_note = 1'b1;
          load_dur   = pend_dur;
        end else begin
          start_note = wr_start;
        end
`else
        start_note = wr_start;
`endif
      end else begin
`ifdef GEN_AUDIO_PENDING_EN
        start_note = 1'b0;
`else
        start_note = wr_start;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      period_q <= '0;
      per_act  <= '0;
      dur_q    <= '0;
      tick_cnt <= '0;
      half_cnt <= '0;
      audio    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= end_note;
      if (wr_period) period_q <= bus.din;
      if (state == PLAY) begin
        tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
        if (tick_last) dur_q <= dur_q - 8'd1;
        if (half_last) begin
          half_cnt <= '0;
          audio    <= ~audio;
          per_act  <= period_q;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end
      // Later assignments override the free-running counter updates above.
      if (state == PLAY && wr_stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        audio <= 1'b0;
      end else if (start_note) begin
        state    <= PLAY;
        busy     <= 1'b1;
        audio    <= 1'b1;
        dur_q    <= load_dur;
        tick_cnt <= '0;
        half_cnt <= '0;
        per_act  <= period_q;
      end else if (end_note) begin
        state <= IDLE;
        busy  <= 1'b0;
        audio <= 1'b0;
      end
    end
  end

`ifdef GEN_AUDIO_PENDING_EN
  // A start arriving on the end cycle with an empty slot plays directly instead of queuing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= 1'b0;
      pend_dur <= '0;
    end else if (state == PLAY) begin
      if (wr_stop) begin
        pend <= 1'b0;
      end else if (wr_start && (!note_end || pend)) begin
        pend     <= 1'b1;
        pend_dur <= dur_in;
      end else if (note_end) begin
        pend <= 1'b0;
      end
    end
  end
`else
  assign pend = 1'b0;
`endif

endmodule

// File: doc/gen_audio.md
# gen_audio

Square-wave tone generator for the chronometer's buzzer, sitting directly downstream of the datapath's output-port registers. The CPU writes a half-period code and then a duration; the block plays the tone for that many millisecond ticks, reports `busy`, pulses `done`, and can hold one queued note. `busy`/`pend` are read back through the datapath input mux.

## Interface
Parameters:
- `WIDTH`, 8: data width of the output-port bus.
- `PRESC`, 256: clk cycles per half-period unit.
- `TICK_DIV`, 50000: clk cycles per duration tick (1 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `we`  in  1  write strobe, one cycle, from the output-port decode enable.
- `addr`  in  1  0 = period register, 1 = duration/start command.
- `din`  in  WIDTH  write data.
- `audio`  out  1  square wave to buzzer.
- `busy`  out  1  a note is playing.
- `pend`  out  1  a queued note is waiting.
- `done`  out  1  one-cycle pulse when a note ends normally.

## Operation
- Reset (`reset`=0): `audio`=0, `busy`=0, `pend`=0, `done`=0, period reg=0, all counters=0, state IDLE. Applies immediately, including mid-note.
- States: IDLE, PLAY.
- `we`&&`addr`=0: period reg <= `din`. Half-period = (period+1)*PRESC cycles. A write while playing takes effect at the next toggle boundary; the current half-period is not cut short.
- `we`&&`addr`=1, `din`≠0:
  - IDLE -> PLAY. Load duration counter = `din`. Clear the prescaler and tick counters. Set `audio`=1.
  - PLAY: store `din` in the pending slot and set `pend`=1. If the slot is already full, overwrite it.
- `we`&&`addr`=1, `din`=0: stop command.
  - PLAY -> IDLE. `audio`=0, `pend`=0, `done` not pulsed.
  - Ignored in IDLE.
- PLAY:
  - `audio` toggles each half-period.
  - Each TICK_DIV cycles, decrement the duration counter.
  - When it reaches 0: `done`=1 for one cycle and `audio`=0.
    - If `pend`=1: load the pending duration, clear `pend`, restart the counters, set `audio`=1, stay in PLAY.
    - Otherwise go to IDLE.
- Simultaneous events:
  - Start write in the same cycle a note ends with the slot empty: the new note starts directly (no IDLE cycle). `done` still pulses.
  - Stop in the same cycle as note end: stop wins. No `done`, no promotion.
  - Period write in the same cycle as a start: the new period is used for the note.
- Counters: duration 8-bit, tick counter ceil(log2(TICK_DIV)) bits, half-period counter WIDTH+ceil(log2(PRESC)) bits. No overflow is possible by construction.

## Timing
- Start write sampled at edge N: `busy`=1 and `audio`=1 after edge N.
- First toggle at edge N+(period+1)*PRESC.
- A note of duration D ends at edge N+D*TICK_DIV: `audio`=0, `done`=1 for that cycle only, `busy`=0 unless promoting.
- On promotion, `busy` stays 1 continuously and `audio` is high again after the same edge.
- Stop write at edge M: `audio`=0, `busy`=0 after edge M.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `GEN_AUDIO_PENDING_EN` defined: one-entry pending slot as described above.
- Not defined:
  - A start write during PLAY restarts immediately with the new duration: counters cleared, `audio`=1, no `done` pulse.
  - `pend` is tied to 0.

## Test plan
Bench uses TICK_DIV=10, PRESC=4.
- Reset mid-note: period=1, start D=3; assert `reset`=0 at cycle 5 -> `audio`/`busy`/`done`=0 immediately. They stay 0 after release until a new start.
- Basic note: period=1, start D=3 -> `audio` high 8 cycles and low 8 cycles, repeating. `busy` high 30 cycles. `done` pulses once at cycle 30, then `audio`=0.
- Queued note (macro on): start D=2, then start D=1 at cycle 4 -> `pend`=1. At cycle 20, `done` pulses, `pend`=0, `audio`=1, `busy` stays 1. `busy` drops at cycle 30.
- Overwrite and stop (macro on): start D=5, queue 2, queue 7 -> pend holds 7. Stop at cycle 12 -> `busy`=0, `pend`=0, no `done`.
- Period change mid-note: period=0, start D=4, write period=3 at cycle 2 -> the first toggle stays at cycle 4, and the following half-periods are 16 cycles each.
- Macro off: start D=3, start D=2 at cycle 15 -> counters restart, note ends at cycle 35, single `done`, `pend` always 0.
